// File: rtl/pe_stream_ctrl.sv
// ---------------------------------------------------------------------------
// pe_stream_ctrl
//
// Streaming controller and datapath for one multiply-accumulate processing
// element. A rising edge on start (while idle) latches len and mode. The
// block then reads len packed words from BRAM port A, one per cycle, and
// writes results to BRAM port B.
//   mode 0 (elementwise): word k -> y_k + a_k*b_k, fitted to DATA_W and
//                         sign-extended, written to addrb = 4k.
//   mode 1 (dot product): acc = y_0 + sum(a_k*b_k), one write to addrb = 0.
// Word packing on douta: a = [DATA_W-1:0], b = [2*DATA_W-1:DATA_W],
//                        y = [3*DATA_W-1:2*DATA_W], all signed.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   start            control level; a rising edge while idle starts a run
//   len, mode        run length and mode, sampled on the accepted edge
//   ready            high while idle
//   done             one-cycle pulse at the end of a run
//   clka..douta      BRAM port A, read-only use
//   clkb..doutb      BRAM port B, write-only use (doutb unused)
//
// Configuration macro: PE_SAT_EN
//   defined   -> elementwise results saturate to DATA_W signed limits and the
//                dot accumulator saturates at 32-bit signed limits
//   undefined -> both modes wrap
// ---------------------------------------------------------------------------
module pe_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode,
  output logic              ready,
  output logic              done,
  output logic              clka,
  output logic              rsta,
  output logic              ena,
  output logic [31:0]       addra,
  output logic [31:0]       dina,
  output logic [3:0]        wea,
  input  logic [31:0]       douta,
  output logic              clkb,
  output logic              rstb,
  output logic              enb,
  output logic [31:0]       addrb,
  output logic [31:0]       dinb,
  output logic [3:0]        web,
  input  logic [31:0]       doutb
);

  localparam int STAGES = 3;

`ifdef PE_SAT_EN
  localparam logic signed [31:0] EMAX = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
  localparam logic signed [31:0] EMIN = -EMAX - 32'sd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_start_d;
  logic [LEN_W-1:0]   r_len;
  logic               r_mode;
  logic [LEN_W-1:0]   r_cnt;
  logic [1:0]         r_dcnt;
  logic               w_accept;
  logic [LEN_W-1:0]   w_len_m1;

  logic               r_vld_p0;
  logic [LEN_W-1:0]   r_idx_p0;
  logic               r_vld_p1;
  logic [LEN_W-1:0]   r_idx_p1;
  logic signed [DATA_W-1:0] r_a_p1;
  logic signed [DATA_W-1:0] r_b_p1;
  logic signed [DATA_W-1:0] r_y_p1;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [31:0] w_prod_ext;
  logic signed [31:0] w_y_ext;
  logic signed [31:0] w_esum;
  logic signed [31:0] w_acc_base;
  logic [31:0]        w_acc_nxt;
  logic [31:0]        w_elem;
  logic               w_last;
  logic signed [31:0] r_acc;

  logic               r_enb;
  logic [3:0]         r_web;
  logic [31:0]        r_addrb;
  logic [31:0]        r_dinb;

  logic               w_unused_ok;

  // Fit an elementwise sum into DATA_W, returned sign-extended to 32 bits.
  function automatic logic [31:0] elem_fit(input logic signed [31:0] s);
`ifdef PE_SAT_EN
    if (s > EMAX)      return EMAX;
    else if (s < EMIN) return EMIN;
    else               return s;
`else
    return {{(32-DATA_W){s[DATA_W-1]}}, s[DATA_W-1:0]};
`endif
  endfunction

  // 32-bit accumulator add.
  function automatic logic [31:0] acc_add(input logic signed [31:0] x,
                                          input logic signed [31:0] y);
`ifdef PE_SAT_EN
    logic signed [32:0] s;
    s = {x[31], x} + {y[31], y};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
`else
    return x + y;
`endif
  endfunction

  assign clka  = clk;
  assign clkb  = clk;
  assign rsta  = rst;
  assign rstb  = rst;
  assign dina  = 32'd0;
  assign wea   = 4'd0;

  assign w_unused_ok = ^{doutb, douta};

  assign w_accept = (r_state == S_IDLE) && start && !r_start_d;
  assign w_len_m1 = r_len - LEN_W'(1);

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign ena   = (r_state == S_READ);
  assign addra = (r_state == S_READ) ? {{(30-LEN_W){1'b0}}, r_cnt, 2'b00} : 32'd0;

  assign enb   = r_enb;
  assign web   = r_web;
  assign addrb = r_addrb;
  assign dinb  = r_dinb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (len == '0) ? S_DONE : S_READ;
      S_READ:  if (r_cnt == w_len_m1) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_dcnt == 2'(STAGES - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping: start edge detect, latched run parameters, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_cnt     <= '0;
      r_dcnt    <= '0;
    end else begin
      r_start_d <= start;
      if (w_accept) begin
        r_len  <= len;
        r_mode <= mode;
        r_cnt  <= '0;
      end
      if (r_state == S_READ) begin
        r_cnt  <= r_cnt + LEN_W'(1);
        r_dcnt <= '0;
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 2'd1;
    end
  end

  // p0: read issued this cycle, BRAM data appears on douta next cycle
  always_ff @(posedge clk) begin
    if (rst) r_vld_p0 <= 1'b0;
    else     r_vld_p0 <= (r_state == S_READ);
  end

  always_ff @(posedge clk) begin
    r_idx_p0 <= r_cnt;
  end

  // p1: input register stage holding the unpacked operands
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= r_vld_p0;
  end

  always_ff @(posedge clk) begin
    r_idx_p1 <= r_idx_p0;
    r_a_p1   <= douta[DATA_W-1:0];
    r_b_p1   <= douta[2*DATA_W-1:DATA_W];
    r_y_p1   <= douta[3*DATA_W-1:2*DATA_W];
  end

  // Combinational MAC between p1 and the output register stage
  assign w_prod     = r_a_p1 * r_b_p1;
  assign w_prod_ext = {{(32-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_y_ext    = {{(32-DATA_W){r_y_p1[DATA_W-1]}}, r_y_p1};
  assign w_esum     = w_y_ext + w_prod_ext;
  assign w_elem     = elem_fit(w_esum);
  // Word 0 seeds the accumulator with its y field; later y fields are ignored.
  assign w_acc_base = (r_idx_p1 == '0) ? w_y_ext : r_acc;
  assign w_acc_nxt  = acc_add(w_acc_base, w_prod_ext);
  assign w_last     = (r_idx_p1 == w_len_m1);

  // p2: output register stage driving BRAM port B
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enb   <= 1'b0;
      r_web   <= 4'd0;
      r_addrb <= 32'd0;
      r_dinb  <= 32'd0;
      r_acc   <= 32'sd0;
    end else begin
      r_enb <= 1'b0;
      r_web <= 4'd0;
      if (w_accept) r_acc <= 32'sd0;
      if (r_vld_p1) begin
        if (!r_mode) begin
          r_enb   <= 1'b1;
          r_web   <= 4'hF;
          r_addrb <= {{(30-LEN_W){1'b0}}, r_idx_p1, 2'b00};
          r_dinb  <= w_elem;
        end else begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_enb   <= 1'b1;
            r_web   <= 4'hF;
            r_addrb <= 32'd0;
            r_dinb  <= w_acc_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pe_stream_ctrl. A behavioural BRAM feeds port A; all port B
// writes, port A reads and done pulses are logged with their cycle number and
// compared against a list of expected events built from the arithmetic rules.
// ---------------------------------------------------------------------------
module tb_pe_stream_ctrl;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len_i;
  logic          mode;
  logic          ready, done;
  logic          clka, rsta, ena, clkb, rstb, enb;
  logic [31:0]   addra, dina, douta, addrb, dinb, doutb;
  logic [3:0]    wea, web;

  pe_stream_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len_i), .mode(mode),
    .ready(ready), .done(done),
    .clka(clka), .rsta(rsta), .ena(ena), .addra(addra), .dina(dina),
    .wea(wea), .douta(douta),
    .clkb(clkb), .rstb(rstb), .enb(enb), .addrb(addrb), .dinb(dinb),
    .web(web), .doutb(doutb)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign doutb = 32'd0;

  always @(posedge clk) if (ena) douta <= mem[addra[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_web[$];
  int          rd_cyc[$];
  logic [31:0] rd_addr[$];
  int          dn_cyc[$];

  always @(negedge clk) begin
    if (enb || web != 4'd0) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(addrb);
      wr_data.push_back(dinb); wr_web.push_back(web);
    end
    if (ena) begin rd_cyc.push_back(cyc); rd_addr.push_back(addra); end
    if (done) dn_cyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int y);
    logic [31:0] r;
    r = $urandom;
    r[7:0] = a[7:0]; r[15:8] = b[7:0]; r[23:16] = y[7:0];
    return r;
  endfunction

  function automatic int fa(input logic [31:0] w); return $signed(w[7:0]);   endfunction
  function automatic int fb(input logic [31:0] w); return $signed(w[15:8]);  endfunction
  function automatic int fy(input logic [31:0] w); return $signed(w[23:16]); endfunction

  function automatic int elem_ref(input int s);
    int t;
`ifdef PE_SAT_EN
    t = (s > 127) ? 127 : (s < -128) ? -128 : s;
`else
    t = s & 255;
    if (t > 127) t = t - 256;
`endif
    return t;
  endfunction

  function automatic int acc_ref(input int acc, input int p);
`ifdef PE_SAT_EN
    longint t;
    t = longint'(acc) + longint'(p);
    if (t > 64'sd2147483647) t = 64'sd2147483647;
    if (t < -64'sd2147483648) t = -64'sd2147483648;
    return int'(t);
`else
    return acc + p;
`endif
  endfunction

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_web.delete();
    rd_cyc.delete(); rd_addr.delete(); dn_cyc.delete();
  endtask

  // One run: n words from mem[0..n-1]; start dropped after `hold` cycles;
  // optional extra rising edge on start while the run is in progress.
  task automatic run_case(input bit m, input int n, input int hold, input bit glitch);
    int          e_cyc[$];
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    int S, D, lim, acc, k;
    bit seen;
    if (!m) begin
      for (k = 0; k < n; k++) begin
        e_cyc.push_back(k + 4); e_addr.push_back(32'(4 * k));
        e_data.push_back(elem_ref(fy(mem[k]) + fa(mem[k]) * fb(mem[k])));
      end
    end else if (n > 0) begin
      acc = fy(mem[0]);
      for (k = 0; k < n; k++) acc = acc_ref(acc, fa(mem[k]) * fb(mem[k]));
      e_cyc.push_back(n + 3); e_addr.push_back(32'd0); e_data.push_back(acc);
    end
    @(negedge clk);
    clear_logs();
    mode = m; len_i = LW'(n); start = 1'b1; S = cyc;
    seen = 1'b0; D = 0;
    lim = (n + 30 > hold + 10) ? n + 30 : hold + 10;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (i == 1) begin mode = ~m; len_i = LW'($urandom_range(1, 40)); end
      if (glitch && i == 2) start = 1'b0;
      if (glitch && i == 3) start = 1'b1;
      if (i == hold) start = 1'b0;
      if (done && !seen) begin
        seen = 1'b1; D = cyc;
        check("ready_low_at_done", ready, 0);
      end else if (seen && cyc == D + 1) begin
        check("ready_after_done", ready, 1);
      end
      if (seen && cyc >= D + 3 && i > hold + 2) break;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) check("done_cycle", dn_cyc[0] - S, (n == 0) ? 1 : n + 4);
    check("read_count", rd_cyc.size(), n);
    for (int i = 0; i < rd_cyc.size() && i < n; i++) begin
      check("read_cycle", rd_cyc[i] - S, i + 1);
      check("read_addr", rd_addr[i], 32'(4 * i));
    end
    check("write_count", wr_cyc.size(), e_cyc.size());
    for (int i = 0; i < wr_cyc.size() && i < e_cyc.size(); i++) begin
      check("write_cycle", wr_cyc[i] - S, e_cyc[i]);
      check("write_addr", wr_addr[i], e_addr[i]);
      check("write_data", wr_data[i], e_data[i]);
      check("write_web", wr_web[i], 4'hF);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int S;
    rst = 1'b1; start = 1'b0; mode = 1'b0; len_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_ena", ena, 0);
    check("rst_enb", enb, 0);
    check("rst_web", web, 0);
    check("rst_addra", addra, 0);
    check("rst_addrb", addrb, 0);
    check("rst_dinb", dinb, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Elementwise directed words
    mem[0] = pack(2, 3, 1); mem[1] = pack(-4, 5, 10); mem[2] = pack(7, 7, 0);
    run_case(1'b0, 3, 1, 1'b0);

    // Wrap / saturate boundary
    mem[0] = pack(100, 2, 100);
    run_case(1'b0, 1, 1, 1'b0);
    mem[0] = pack(-128, 127, -128);
    run_case(1'b0, 1, 1, 1'b0);

    // Dot product directed
    mem[0] = pack(1, 5, 10); mem[1] = pack(2, 6, 3);
    mem[2] = pack(3, 7, -7); mem[3] = pack(4, 8, 9);
    run_case(1'b1, 4, 1, 1'b0);

    // len = 0, held start, mid-run start edge
    run_case(1'b0, 0, 1, 1'b0);
    run_case(1'b1, 0, 1, 1'b0);
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    run_case(1'b0, 3, 20, 1'b0);
    run_case(1'b1, 8, 6, 1'b1);

    // Reset in the middle of a len = 8 elementwise run
    @(negedge clk);
    clear_logs();
    mode = 1'b0; len_i = LW'(8); start = 1'b1; S = cyc;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_enb", enb, 0);
    check("abort_web", web, 0);
    check("abort_ready", ready, 1);
    check("abort_cycle", cyc - S, 4);
    repeat (15) @(negedge clk);
    check("abort_writes", wr_cyc.size(), 0);
    check("abort_done", dn_cyc.size(), 0);
    run_case(1'b0, 5, 1, 1'b0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      if (r == 5) for (int i = 0; i < 16; i++) mem[i] = pack(-128, -128, 127);
      run_case(1'($urandom_range(0, 1)), $urandom_range(1, 16), $urandom_range(1, 4), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
